// File: rtl/altivec_issue_ctrl.sv
// altivec_issue_ctrl: collects go1/go2/go3, launches one op on VSFX or PU, tracks completion or timeout
module altivec_issue_ctrl #(
  parameter int OPC_W   = 11,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go1,
  input  logic             go2,
  input  logic             go3,
  input  logic             unit_sel,
  input  logic [OPC_W-1:0] opc,
  output logic             vsfx_start,
  output logic             pu_start,
  output logic [OPC_W-1:0] opc_out,
  input  logic             vsfx_done,
  input  logic             pu_done,
  output logic             dut_busy,
  output logic             result_valid,
  output logic             timeout_err,
  output logic             overrun_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] seen_q, seen_d, go;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic sel_q, sel_d, to_q, to_d, ovr_q, ovr_d;
  logic collecting, complete, done, hit, leave;
  assign go = {go3, go2, go1};
  assign collecting = state_q == IDLE || state_q == COLLECT;
  assign complete = &(seen_q | go);
  assign done = sel_q ? pu_done : vsfx_done;
  assign hit = cnt_q == CNT_MAX;
  assign leave = done || hit;
  always_comb begin
    state_d = state_q;
    seen_d = seen_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    to_d = to_q;
    opc_d = opc_q;
    ovr_d = ovr_q | (!collecting && |go);
    case (state_q)
      IDLE, COLLECT: begin
        seen_d = complete ? 3'b000 : seen_q | go;
        state_d = complete ? ISSUE : (|go ? COLLECT : state_q);
        sel_d = complete ? unit_sel : sel_q;
        opc_d = complete ? opc : opc_q;
      end
      ISSUE: begin
        cnt_d = '0;
        to_d = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        state_d = leave ? DONE : WAIT;
        to_d = !done && hit;
        cnt_d = leave ? cnt_q : cnt_q + CW'(1);
      end
      DONE: begin
        seen_d = 3'b000;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seen_q <= 3'b000;
      cnt_q <= '0;
      sel_q <= 1'b0;
      to_q <= 1'b0;
      ovr_q <= 1'b0;
      opc_q <= '0;
    end else begin
      state_q <= state_d;
      seen_q <= seen_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      to_q <= to_d;
      ovr_q <= ovr_d;
      opc_q <= opc_d;
    end
  end
  assign vsfx_start = state_q == ISSUE && !sel_q;
  assign pu_start = state_q == ISSUE && sel_q;
  assign opc_out = opc_q;
  assign dut_busy = collecting ? complete : 1'b1;
  assign result_valid = state_q == DONE;
  assign timeout_err = result_valid && to_q;
  assign overrun_err = ovr_q;
endmodule

// File: tb/tb_altivec_issue_ctrl.sv
// tb_altivec_issue_ctrl: directed and randomized checks of the issue sequencer against a transaction-level model
module tb_altivec_issue_ctrl;
  localparam int TIMEOUT = 16;
  logic clk, rst_n, go1, go2, go3, unit_sel, vsfx_done, pu_done;
  logic [10:0] opc, opc_out;
  logic vsfx_start, pu_start, dut_busy, result_valid, timeout_err, overrun_err;
  int checks = 0, errors = 0, cyc = 0;
  bit m_active, m_sel, m_to, m_ovr, n_active, n_sel, n_to, n_ovr;
  bit [2:0] m_seen, n_seen;
  int m_t = 0, m_res = -1, n_t, n_res;
  logic [10:0] m_opc = '0, n_opc;
  bit e_busy, e_vs, e_pu, e_rv, e_to, e_ovr;
  logic [10:0] e_opc;
  altivec_issue_ctrl #(.OPC_W(11), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .go1(go1), .go2(go2), .go3(go3),
    .unit_sel(unit_sel), .opc(opc), .vsfx_start(vsfx_start), .pu_start(pu_start),
    .opc_out(opc_out), .vsfx_done(vsfx_done), .pu_done(pu_done), .dut_busy(dut_busy),
    .result_valid(result_valid), .timeout_err(timeout_err), .overrun_err(overrun_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic eval();
    bit [2:0] g;
    bit dn;
    g = {go3, go2, go1};
    n_active = m_active; n_t = m_t; n_sel = m_sel; n_res = m_res; n_to = m_to;
    n_seen = m_seen; n_ovr = m_ovr; n_opc = m_opc;
    e_ovr = m_ovr; e_opc = m_opc; e_vs = 0; e_pu = 0; e_rv = 0; e_to = 0;
    if (m_active) begin
      e_busy = 1;
      e_vs = cyc == m_t + 1 && !m_sel;
      e_pu = cyc == m_t + 1 && m_sel;
      e_rv = cyc == m_res;
      e_to = e_rv && m_to;
      if (g != 0) n_ovr = 1;
      dn = m_sel ? pu_done : vsfx_done;
      if (m_res < 0 && cyc >= m_t + 2 && dn) begin n_res = cyc + 1; n_to = 0; end
      else if (m_res < 0 && cyc == m_t + 1 + TIMEOUT) begin n_res = cyc + 1; n_to = 1; end
      if (cyc == m_res) n_active = 0;
    end else begin
      e_busy = &(m_seen | g);
      if (e_busy) begin
        n_active = 1; n_t = cyc; n_sel = unit_sel; n_opc = opc; n_res = -1; n_seen = 0;
      end else n_seen = m_seen | g;
    end
    if (!rst_n) begin n_active = 0; n_seen = 0; n_ovr = 0; n_opc = 0; end
  endtask
  task automatic drive(input bit r, a, b, c, s, input logic [10:0] op, input bit vd, pd);
    rst_n = r; go1 = a; go2 = b; go3 = c; unit_sel = s; opc = op; vsfx_done = vd; pu_done = pd;
    #1;
    eval();
  endtask
  task automatic tick();
    @(posedge clk);
    m_active = n_active; m_t = n_t; m_sel = n_sel; m_res = n_res; m_to = n_to;
    m_seen = n_seen; m_ovr = n_ovr; m_opc = n_opc;
    cyc++;
    @(negedge clk);
  endtask
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin drive(0, 0, 0, 0, 0, 11'h7FF, 1, 1); tick(); end
    drive(1, 0, 0, 0, 0, 11'h000, 0, 0);
    checks++; if (dut_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", dut_busy); end
    checks++; if (vsfx_start !== 1'b0 || pu_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b%b exp 00", vsfx_start, pu_start); end
    checks++; if (result_valid !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_result got %b%b exp 00", result_valid, timeout_err); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun_err); end
    checks++; if (opc_out !== 11'h000) begin errors++; $display("FAIL reset_opc got %h exp 000", opc_out); end
    tick();
  endtask
  task automatic test_basic();
    for (int k = 0; k < 5; k++) begin
      drive(1, k == 0, k == 0, k == 0, 0, 11'h0C0, k == 2, 0);
      checks++; if (dut_busy !== 1'(k < 4)) begin errors++; $display("FAIL basic_busy k=%0d got %b exp %b", k, dut_busy, k < 4); end
      checks++; if (vsfx_start !== 1'(k == 1) || pu_start !== 1'b0) begin errors++; $display("FAIL basic_start k=%0d got %b%b", k, vsfx_start, pu_start); end
      checks++; if (result_valid !== 1'(k == 3)) begin errors++; $display("FAIL basic_rv k=%0d got %b exp %b", k, result_valid, k == 3); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL basic_to k=%0d got %b exp 0", k, timeout_err); end
      if (k >= 1) begin checks++; if (opc_out !== 11'h0C0) begin errors++; $display("FAIL basic_opc k=%0d got %h exp 0c0", k, opc_out); end end
      tick();
    end
  endtask
  task automatic test_spread();
    for (int k = 0; k < 10; k++) begin
      drive(1, k == 0, k == 5, k == 2, 1, 11'h155, 0, k == 7);
      checks++; if (dut_busy !== 1'(k >= 5 && k <= 8)) begin errors++; $display("FAIL spread_busy k=%0d got %b", k, dut_busy); end
      checks++; if (pu_start !== 1'(k == 6) || vsfx_start !== 1'b0) begin errors++; $display("FAIL spread_start k=%0d got vs=%b pu=%b", k, vsfx_start, pu_start); end
      checks++; if (result_valid !== 1'(k == 8)) begin errors++; $display("FAIL spread_rv k=%0d got %b", k, result_valid); end
      tick();
    end
  endtask
  task automatic test_timeout();
    for (int k = 0; k < 20; k++) begin
      drive(1, k == 0, k == 0, k == 0, 1, 11'h2AA, 1, 0);
      checks++; if (pu_start !== 1'(k == 1)) begin errors++; $display("FAIL to_start k=%0d got %b", k, pu_start); end
      checks++; if (result_valid !== 1'(k == 18) || timeout_err !== 1'(k == 18)) begin errors++; $display("FAIL to_result k=%0d got rv=%b te=%b", k, result_valid, timeout_err); end
      checks++; if (dut_busy !== 1'(k <= 18)) begin errors++; $display("FAIL to_busy k=%0d got %b", k, dut_busy); end
      tick();
    end
  endtask
  task automatic test_race();
    for (int k = 0; k < 20; k++) begin
      drive(1, k == 0, k == 0, k == 0, 0, 11'h033, k == 17, 1);
      checks++; if (result_valid !== 1'(k == 18) || timeout_err !== 1'b0) begin errors++; $display("FAIL race_result k=%0d got rv=%b te=%b", k, result_valid, timeout_err); end
      checks++; if (dut_busy !== 1'(k <= 18)) begin errors++; $display("FAIL race_busy k=%0d got %b", k, dut_busy); end
      tick();
    end
  endtask
  task automatic test_overrun();
    for (int k = 0; k < 13; k++) begin
      drive(1, k == 0 || k == 7, k == 0 || k == 3 || k == 8, k == 0 || k == 7, 1, 11'h401, k == 2, k == 5 || k == 10);
      checks++; if (overrun_err !== 1'(k >= 4)) begin errors++; $display("FAIL ovr_flag k=%0d got %b", k, overrun_err); end
      checks++; if (result_valid !== 1'(k == 6 || k == 11)) begin errors++; $display("FAIL ovr_rv k=%0d got %b", k, result_valid); end
      if (k == 6) begin checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL ovr_to got %b exp 0", timeout_err); end end
      if (k == 7 || k == 8) begin checks++; if (dut_busy !== 1'(k == 8)) begin errors++; $display("FAIL ovr_busy k=%0d got %b", k, dut_busy); end end
      checks++; if (pu_start !== 1'(k == 1 || k == 9)) begin errors++; $display("FAIL ovr_start k=%0d got %b", k, pu_start); end
      tick();
    end
  endtask
  task automatic test_reset_mid();
    for (int k = 0; k < 9; k++) begin
      drive(k != 2, k == 0 || k == 4, k == 0 || k == 4, k == 0 || k == 4, 0, 11'h0F0, k == 2 || k == 6, 0);
      if (k == 3) begin
        checks++; if (dut_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", dut_busy); end
        checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL rstmid_ovr got %b exp 0", overrun_err); end
      end
      checks++; if (result_valid !== 1'(k == 7)) begin errors++; $display("FAIL rstmid_rv k=%0d got %b", k, result_valid); end
      checks++; if (vsfx_start !== 1'(k == 1 || k == 5)) begin errors++; $display("FAIL rstmid_start k=%0d got %b", k, vsfx_start); end
      tick();
    end
  endtask
  task automatic test_back_to_back();
    for (int k = 0; k < 14; k++) begin
      drive(1, k < 12, k < 12, k < 12, 0, 11'(k), 1, 0);
      checks++; if (vsfx_start !== 1'(k % 4 == 1 && k < 12)) begin errors++; $display("FAIL b2b_start k=%0d got %b", k, vsfx_start); end
      checks++; if (dut_busy !== 1'(k < 12)) begin errors++; $display("FAIL b2b_busy k=%0d got %b", k, dut_busy); end
      tick();
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      int dp;
      dp = (i / 300) % 2 == 0 ? 25 : 3;
      drive($urandom_range(0, 149) != 0, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 30, 1'($urandom), 11'($urandom),
            $urandom_range(0, 99) < dp, $urandom_range(0, 99) < dp);
      checks++; if (dut_busy !== e_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got %b exp %b", cyc, dut_busy, e_busy); end
      checks++; if (vsfx_start !== e_vs) begin errors++; $display("FAIL rnd_vs cyc=%0d got %b exp %b", cyc, vsfx_start, e_vs); end
      checks++; if (pu_start !== e_pu) begin errors++; $display("FAIL rnd_pu cyc=%0d got %b exp %b", cyc, pu_start, e_pu); end
      checks++; if (result_valid !== e_rv) begin errors++; $display("FAIL rnd_rv cyc=%0d got %b exp %b", cyc, result_valid, e_rv); end
      checks++; if (timeout_err !== e_to) begin errors++; $display("FAIL rnd_to cyc=%0d got %b exp %b", cyc, timeout_err, e_to); end
      checks++; if (overrun_err !== e_ovr) begin errors++; $display("FAIL rnd_ovr cyc=%0d got %b exp %b", cyc, overrun_err, e_ovr); end
      checks++; if (opc_out !== e_opc) begin errors++; $display("FAIL rnd_opc cyc=%0d got %h exp %h", cyc, opc_out, e_opc); end
      tick();
    end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_spread();
    test_timeout();
    test_race();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
